system_bus_arbiter: RTL and testbench

Shares the single CPU system bus between two requesters: the instruction fetch unit (port `if_`) and the load/store unit (port `mem_`). Arbitrates request cycles round-robin, forwards the winner's address, data and strobes to the bus, and tracks outstanding reads in an in-order tag FIFO. Returned `system_bus_read_data_valid` beats go only to the requester that issued the read. Sits between the CPU pipeline units and the top-level `system_bus_*` ports.

---
 rtl/system_bus_arbiter_if.sv | 23 ++
 rtl/system_bus_arbiter.sv | 110 +++++++++++
 tb/tb_system_bus_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/system_bus_arbiter_if.sv
// Request/return bundle shared by the two CPU requesters and the system bus.
// The requester side (or the arbiter facing the system bus) uses the master
// modport; the side accepting requests uses the slave modport.
interface system_bus_arbiter_if;
    logic        ready;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic [3:0]  byte_enable;
    logic        write_req;
    logic        read_req;
    logic [31:0] read_data;
    logic        read_data_valid;

    modport master (
        output addr, write_data, byte_enable, write_req, read_req,
        input  ready, read_data, read_data_valid
    );

    modport slave (
        input  addr, write_data, byte_enable, write_req, read_req,
        output ready, read_data, read_data_valid
    );
endinterface

// File: rtl/system_bus_arbiter.sv
// Two-port round-robin arbiter for the CPU system bus. Forwards the granted
// request combinationally and routes in-order read returns using a tag FIFO
// that remembers which port issued each outstanding read.
module system_bus_arbiter #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    system_bus_arbiter_if.slave         if_,
    system_bus_arbiter_if.slave         mem_,
    system_bus_arbiter_if.master        system_bus,
    output logic                        protocol_error
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MAX_OUTSTANDING);
    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    logic                       last_grant;
    logic [MAX_OUTSTANDING-1:0] tag_q;
    logic [PW-1:0]              wr_ptr, rd_ptr;
    logic [CW-1:0]              count;

    logic if_req, mem_req, any_req, grant;
    logic sel_write, sel_read, fifo_full;
    logic drive_write, drive_read, accept, push, pop, head_tag;

    // Who owns the bus this cycle: lone requester, or the one not served last on a tie.
    always_comb begin
        if_req  = if_.write_req | if_.read_req;
        mem_req = mem_.write_req | mem_.read_req;
        any_req = if_req | mem_req;
        grant   = (mem_req && (!if_req || last_grant == GRANT_IF)) ? GRANT_MEM : GRANT_IF;
    end

    // Mux the granted port onto the bus; a write on the same port hides its read.
    always_comb begin
        system_bus.addr        = '0;
        system_bus.write_data  = '0;
        system_bus.byte_enable = '0;
        sel_write              = 1'b0;
        sel_read               = 1'b0;
        if (any_req) begin
            if (grant == GRANT_MEM) begin
                system_bus.addr        = mem_.addr;
                system_bus.write_data  = mem_.write_data;
                system_bus.byte_enable = mem_.byte_enable;
                sel_write              = mem_.write_req;
                sel_read               = mem_.read_req & ~mem_.write_req;
            end else begin
                system_bus.addr        = if_.addr;
                system_bus.write_data  = if_.write_data;
                system_bus.byte_enable = if_.byte_enable;
                sel_write              = if_.write_req;
                sel_read               = if_.read_req & ~if_.write_req;
            end
        end
    end

    // Full uses the registered count only, so a same-cycle pop never frees a slot early.
    assign fifo_full   = (count == FULL_CNT);
    assign drive_write = reset_n & sel_write;
    assign drive_read  = reset_n & sel_read & ~fifo_full;
    assign accept      = (drive_write | drive_read) & system_bus.ready;
    assign push        = accept & drive_read;

    assign system_bus.write_req = drive_write;
    assign system_bus.read_req  = drive_read;
    assign if_.ready            = accept & (grant == GRANT_IF);
    assign mem_.ready           = accept & (grant == GRANT_MEM);

    // Return path: data is broadcast, the FIFO head decides who sees the valid.
    assign head_tag             = tag_q[rd_ptr];
    assign pop                  = reset_n & system_bus.read_data_valid & (count != '0);
    assign if_.read_data        = system_bus.read_data;
    assign mem_.read_data       = system_bus.read_data;
    assign if_.read_data_valid  = pop & (head_tag == GRANT_IF);
    assign mem_.read_data_valid = pop & (head_tag == GRANT_MEM);

    // Remember the last accepted port; reset favours if_ on the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    last_grant <= GRANT_MEM;
        else if (accept) last_grant <= grant;
    end

    // Tag FIFO: push issuing port on read accept, pop on each return beat.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tag_q  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                tag_q[wr_ptr] <= grant;
                wr_ptr        <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    // Sticky flag for a return beat that no read is waiting for.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                                          protocol_error <= 1'b0;
        else if (system_bus.read_data_valid && count == '0)    protocol_error <= 1'b1;
    end
endmodule

// File: tb/tb_system_bus_arbiter.sv
// Directed bench for system_bus_arbiter: a vector table for arbitration and
// return routing, then hand-written sequences for FIFO-full, bus stall,
// push/pop pointer wrap, protocol error and reset.
module tb_system_bus_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic protocol_error;
    int   n_cmp = 0;
    int   n_bad = 0;

    system_bus_arbiter_if if_bus ();
    system_bus_arbiter_if mem_bus ();
    system_bus_arbiter_if sys_bus ();

    system_bus_arbiter #(.MAX_OUTSTANDING(4)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .if_            (if_bus),
        .mem_           (mem_bus),
        .system_bus     (sys_bus),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        if_wr, if_rd, mem_wr, mem_rd;
        logic [31:0] if_addr, mem_addr;
        logic        bus_rdy, rdv;
        logic [31:0] rdata;
        logic        e_if_rdy, e_mem_rdy, e_bwr, e_brd;
        logic [31:0] e_addr;
        logic        e_if_rdv, e_mem_rdv, e_perr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic iw, ir, mw, mr, input logic [31:0] ia, ma,
                         input logic brdy, rdv, input logic [31:0] rd);
        if_bus.write_req        = iw;
        if_bus.read_req         = ir;
        if_bus.addr             = ia;
        if_bus.write_data       = 32'h0;
        if_bus.byte_enable      = 4'hf;
        mem_bus.write_req       = mw;
        mem_bus.read_req        = mr;
        mem_bus.addr            = ma;
        mem_bus.write_data      = 32'h0;
        mem_bus.byte_enable     = 4'hf;
        sys_bus.ready           = brdy;
        sys_bus.read_data_valid = rdv;
        sys_bus.read_data       = rd;
    endtask

    task automatic chk_req(input string nm, input logic irdy, mrdy, bwr, brd);
        chk({nm, ".if_ready"},  if_bus.ready,      irdy);
        chk({nm, ".mem_ready"}, mem_bus.ready,     mrdy);
        chk({nm, ".bus_wr"},    sys_bus.write_req, bwr);
        chk({nm, ".bus_rd"},    sys_bus.read_req,  brd);
    endtask

    task automatic chk_ret(input string nm, input logic irdv, mrdv);
        chk({nm, ".if_rdv"},  if_bus.read_data_valid,  irdv);
        chk({nm, ".mem_rdv"}, mem_bus.read_data_valid, mrdv);
    endtask

    initial begin
        logic [7:0] pat;
        // if_wr if_rd mem_wr mem_rd if_addr mem_addr rdy rdv rdata | if_rdy mem_rdy bwr brd addr if_rdv mem_rdv perr
        vecs[0]  = '{0,1,0,1, 32'h10, 32'h20, 1,0,32'h0,        1,0,0,1, 32'h10,  0,0,0};
        vecs[1]  = '{0,1,0,1, 32'h10, 32'h20, 1,0,32'h0,        0,1,0,1, 32'h20,  0,0,0};
        vecs[2]  = '{0,1,0,1, 32'h10, 32'h20, 1,0,32'h0,        1,0,0,1, 32'h10,  0,0,0};
        vecs[3]  = '{0,1,0,1, 32'h10, 32'h20, 1,0,32'h0,        0,1,0,1, 32'h20,  0,0,0};
        vecs[4]  = '{0,1,0,1, 32'h10, 32'h20, 1,0,32'h0,        0,0,0,0, 32'h10,  0,0,0};
        vecs[5]  = '{0,0,0,0, 32'h0,  32'h0,  1,1,32'hA0,       0,0,0,0, 32'h0,   1,0,0};
        vecs[6]  = '{0,0,0,0, 32'h0,  32'h0,  1,1,32'hA1,       0,0,0,0, 32'h0,   0,1,0};
        vecs[7]  = '{0,0,0,0, 32'h0,  32'h0,  1,1,32'hA2,       0,0,0,0, 32'h0,   1,0,0};
        vecs[8]  = '{0,0,0,0, 32'h0,  32'h0,  1,1,32'hA3,       0,0,0,0, 32'h0,   0,1,0};
        vecs[9]  = '{0,1,0,0, 32'h100,32'h0,  1,0,32'h0,        1,0,0,1, 32'h100, 0,0,0};
        vecs[10] = '{0,0,0,0, 32'h0,  32'h0,  1,1,32'hDEADBEEF, 0,0,0,0, 32'h0,   1,0,0};
        vecs[11] = '{1,1,0,0, 32'h200,32'h0,  1,0,32'h0,        1,0,1,0, 32'h200, 0,0,0};
        vecs[12] = '{0,0,0,0, 32'h0,  32'h0,  0,0,32'h0,        0,0,0,0, 32'h0,   0,0,0};

        // Reset state: requests present but everything gated off.
        drive(1,1,0,1, 32'h10, 32'h20, 1,1,32'h0);
        #2;
        chk_req("reset", 0,0,0,0);
        chk_ret("reset", 0,0);
        chk("reset.perr", protocol_error, 1'b0);
        @(negedge clk);
        drive(0,0,0,0, 0,0, 0,0,0);
        reset_n = 1'b1;

        // Table: round-robin, full blocking, return routing, single read, write priority.
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].if_wr, vecs[i].if_rd, vecs[i].mem_wr, vecs[i].mem_rd,
                  vecs[i].if_addr, vecs[i].mem_addr, vecs[i].bus_rdy, vecs[i].rdv, vecs[i].rdata);
            #2;
            chk_req($sformatf("vec%0d", i), vecs[i].e_if_rdy, vecs[i].e_mem_rdy, vecs[i].e_bwr, vecs[i].e_brd);
            chk($sformatf("vec%0d.addr", i), sys_bus.addr, vecs[i].e_addr);
            chk_ret($sformatf("vec%0d", i), vecs[i].e_if_rdv, vecs[i].e_mem_rdv);
            chk($sformatf("vec%0d.if_rdata", i), if_bus.read_data, vecs[i].rdata);
            chk($sformatf("vec%0d.mem_rdata", i), mem_bus.read_data, vecs[i].rdata);
            chk($sformatf("vec%0d.perr", i), protocol_error, vecs[i].e_perr);
        end

        // FIFO full: four mem reads fill it.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0,0,0,1, 0, 32'h300 + 32'(i), 1,0,0);
            #2;
            chk_req($sformatf("fill%0d", i), 0,1,0,1);
        end
        @(negedge clk);
        drive(0,0,0,1, 0, 32'h304, 1,0,0);
        #2;
        chk_req("full_block", 0,0,0,0);
        chk("full_block.addr", sys_bus.addr, 32'h304);
        @(negedge clk);
        drive(1,0,0,1, 32'h400, 32'h304, 1,0,0);
        #2;
        chk_req("full_write", 1,0,1,0);
        chk("full_write.addr", sys_bus.addr, 32'h400);
        @(negedge clk);
        drive(0,0,0,1, 0, 32'h304, 1,1,32'hC0);
        #2;
        chk_req("full_pop_same", 0,0,0,0);
        chk_ret("full_pop_same", 0,1);
        @(negedge clk);
        drive(0,0,0,1, 0, 32'h304, 1,0,0);
        #2;
        chk_req("unblock", 0,1,0,1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(0,0,0,0, 0,0, 1,1, 32'hC1 + 32'(i));
            #2;
            chk_ret($sformatf("drain%0d", i), 0,1);
        end

        // Bus stall on an if_ write.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1,0,0,0, 32'h40, 0, (i == 3), 0, 0);
            if_bus.write_data  = 32'h12345678;
            if_bus.byte_enable = 4'h3;
            #2;
            chk_req($sformatf("stall%0d", i), (i == 3), 0, 1, 0);
            chk($sformatf("stall%0d.addr", i),  sys_bus.addr,        32'h40);
            chk($sformatf("stall%0d.wdata", i), sys_bus.write_data,  32'h12345678);
            chk($sformatf("stall%0d.be", i),    sys_bus.byte_enable, 32'h3);
        end

        // Push/pop at count 2 across pointer wrap; 1 = mem issued the read.
        pat = 8'b1001_0110;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (k < 8) drive(0, !pat[k], 0, pat[k], 32'h500 + 32'(k), 32'h600 + 32'(k), 1, (k >= 2), 32'hB0 + 32'(k));
            else       drive(0,0,0,0, 0,0, 1,1, 32'hB0 + 32'(k));
            #2;
            if (k < 8) chk_req($sformatf("wrap%0d", k), !pat[k], pat[k], 0, 1);
            if (k >= 2) chk_ret($sformatf("wrap%0d", k), !pat[k-2], pat[k-2]);
        end

        // Stray beat with nothing outstanding.
        @(negedge clk);
        drive(0,0,0,0, 0,0, 1,1, 32'hEE);
        #2;
        chk_ret("stray", 0,0);
        chk("stray.perr_before", protocol_error, 1'b0);
        @(negedge clk);
        drive(0,0,0,0, 0,0, 1,0,0);
        #2;
        chk("stray.perr_set", protocol_error, 1'b1);
        @(negedge clk);
        drive(0,1,0,0, 32'h700, 0, 1,0,0);
        #2;
        chk("stray.perr_sticky", protocol_error, 1'b1);
        chk_req("pre_reset_read", 1,0,0,1);

        // Mid-operation reset with a read outstanding.
        @(negedge clk);
        drive(0,1,1,0, 32'h700, 32'h800, 1,1,32'h1);
        reset_n = 1'b0;
        #1;
        chk("rst.perr", protocol_error, 1'b0);
        chk_req("rst", 0,0,0,0);
        chk_ret("rst", 0,0);
        @(negedge clk);
        reset_n = 1'b1;
        drive(0,0,0,0, 0,0, 1,1, 32'h2);
        #2;
        chk_ret("post_rst_beat", 0,0);
        @(negedge clk);
        drive(0,1,0,1, 32'h900, 32'hA00, 1,0,0);
        #2;
        chk("post_rst.perr", protocol_error, 1'b1);
        chk_req("post_rst_tie", 1,0,0,1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
